ccx_ic_router: RTL and testbench
================================

CCX_IC_ROUTER -- requirements
Module: ccx_ic_router

Interface
Parameters:
REQ-001 SHALL have parameter NI, default 2, number of initiator ports (1..8).
REQ-002 SHALL have parameter NT, default 4, number of target ports (1..8).
REQ-003 SHALL have parameter AW, default 39, address width.
REQ-004 SHALL have parameter DW, default 64, data width; strobe width SW=DW/8.
REQ-005 SHALL have parameter T_BASE, default all-zero, NT*AW flattened target base addresses; slice t = bits [t*AW +: AW].
REQ-006 SHALL have parameter T_MASK, default all-ones, NT*AW flattened target address masks; sliced as T_BASE.
Ports:
REQ-007 SHALL have port g_clk, input, 1, the only clock.
REQ-008 SHALL have port g_reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have initiator request ports: i_req in NI; i_rtype in NI; i_addr in NI*AW; i_wen in NI; i_strb in NI*SW; i_wdata in NI*DW.
REQ-010 SHALL have initiator response ports: i_gnt out NI; i_err out NI; i_rdata out NI*DW.
REQ-011 SHALL have target request ports: t_req out NT; t_rtype out NT; t_addr out NT*AW; t_wen out NT; t_strb out NT*SW; t_wdata out NT*DW.
REQ-012 SHALL have target response ports: t_gnt in NT; t_err in NT; t_rdata in NT*DW.

Function
REQ-013 SHALL decode initiator i to target t when (i_addr & T_MASK[t]) == T_BASE[t]; when several match, the lowest t SHALL win.
REQ-014 SHALL treat a request matching no target as unmapped: i_gnt=1 in the same cycle, then one cycle later i_err=1 and i_rdata=0.
REQ-015 SHALL arbitrate each target independently, round-robin over the initiators decoding to it; search starts at ptr[t].
REQ-016 SHALL advance ptr[t] to (winner+1) mod NI only on an accepted transfer (t_req & t_gnt).
REQ-017 SHALL lock the selection while t_req=1 and t_gnt=0; a lock SHALL clear when accepted or when the locked initiator deasserts i_req.
REQ-018 SHALL drive t_req=1 iff any initiator decodes to t; t_rtype, t_addr, t_wen, t_strb and t_wdata SHALL come combinationally from the winner, and SHALL be all-zero when t_req=0.
REQ-019 SHALL assert i_gnt[i] combinationally iff i is the winner at its target and t_gnt=1; non-winners SHALL see i_gnt=0.
REQ-020 SHALL register, per initiator, a response-valid bit and a source index on acceptance; in the next cycle i_rdata/i_err SHALL equal that target's t_rdata/t_err, otherwise 0.
REQ-021 SHALL sustain one accepted transfer per cycle per target, back-to-back, with no bubble.
REQ-022 SHALL allow distinct targets to serve distinct initiators in the same cycle with no interaction.
REQ-023 SHALL give a single requester with NI=1 or NT=1 zero added request latency.

Reset
REQ-024 SHALL, when g_reset=1 at a g_clk edge, set all ptr to 0, clear all locks and response-valid bits, so i_err=0, i_rdata=0 next cycle.
REQ-025 SHALL discard any response pending when reset is asserted mid-transfer; no response SHALL appear after reset deasserts.

Structure
REQ-026 SHALL place no typedefs in a package; index widths SHALL be derived with $clog2 locally.
REQ-027 SHALL instantiate sub-module ccx_rr_arbiter (parameter N; ports g_clk, g_reset, req[N], hold, accept, gnt_onehot[N]) once per target.

Verification
REQ-028 SHALL check reset: after g_reset with NI=2, NT=4, all outputs are 0 and initiator 0 wins the first contention.
REQ-029 SHALL check contention: both initiators request the RAM region every cycle with t_gnt=1; grants alternate 0,1,0,1 and each response follows one cycle later.
REQ-030 SHALL check stall lock: initiator 1 is selected and t_gnt is held 0 for 3 cycles while initiator 0 requests; the selection stays on 1 and initiator 0 is granted the cycle after acceptance.
REQ-031 SHALL check unmapped access: address 0x7F_0000_0000 gives i_gnt=1 immediately, then i_err=1 and i_rdata=0.
REQ-032 SHALL check parallel traffic: initiator 0 reads ROM while initiator 1 writes RAM with strb 0xFF in the same cycle; both are granted and both responses return correctly routed.
REQ-033 SHALL check mid-transfer reset: reset asserted the cycle after acceptance; next cycle i_rdata=0 and i_err=0.

Source files
------------

// File: rtl/ccx_ic_router_pkg.sv
// ccx_ic_router_pkg: shared helpers for the interconnect router
package ccx_ic_router_pkg;
  function automatic int unsigned wrap_inc(int unsigned v, int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/ccx_rr_arbiter.sv
// ccx_rr_arbiter: round-robin arbiter with stall lock, one instance per target
module ccx_rr_arbiter
  import ccx_ic_router_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic [N-1:0] req,
  input  logic         hold,
  input  logic         accept,
  output logic [N-1:0] gnt_onehot
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  logic [IW-1:0] ptr, lock_idx, win;
  logic locked;
  int best;
  always_comb begin
    win = '0;
    best = N;
    for (int i = 0; i < N; i++)
      if (req[i] && (i + N - int'(ptr)) % N < best) begin
        best = (i + N - int'(ptr)) % N;
        win = IW'(i);
      end
    // a stalled selection sticks only while its owner keeps requesting
    if (locked && req[lock_idx]) win = lock_idx;
    for (int i = 0; i < N; i++) gnt_onehot[i] = |req && win == IW'(i);
  end
  always_ff @(posedge g_clk)
    if (g_reset) begin
      ptr <= '0;
      locked <= 1'b0;
      lock_idx <= '0;
    end else begin
      locked <= hold;
      lock_idx <= win;
      if (accept) ptr <= IW'(wrap_inc(32'(win), N));
    end
endmodule

// File: rtl/ccx_ic_router.sv
// ccx_ic_router: address-decoded NI x NT crossbar with per-target round-robin
module ccx_ic_router #(
  parameter int NI = 2,
  parameter int NT = 4,
  parameter int AW = 39,
  parameter int DW = 64,
  parameter logic [NT*AW-1:0] T_BASE = '0,
  parameter logic [NT*AW-1:0] T_MASK = '1,
  localparam int SW = DW / 8
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic [NI-1:0]    i_req,
  input  logic [NI-1:0]    i_rtype,
  input  logic [NI*AW-1:0] i_addr,
  input  logic [NI-1:0]    i_wen,
  input  logic [NI*SW-1:0] i_strb,
  input  logic [NI*DW-1:0] i_wdata,
  output logic [NI-1:0]    i_gnt,
  output logic [NI-1:0]    i_err,
  output logic [NI*DW-1:0] i_rdata,
  output logic [NT-1:0]    t_req,
  output logic [NT-1:0]    t_rtype,
  output logic [NT*AW-1:0] t_addr,
  output logic [NT-1:0]    t_wen,
  output logic [NT*SW-1:0] t_strb,
  output logic [NT*DW-1:0] t_wdata,
  input  logic [NT-1:0]    t_gnt,
  input  logic [NT-1:0]    t_err,
  input  logic [NT*DW-1:0] t_rdata
);
  localparam int TW = NT > 1 ? $clog2(NT) : 1;
  logic [NI-1:0][NT-1:0] dec;
  logic [NT-1:0][NI-1:0] treq, oh;
  logic [NI-1:0] mapped, unm, rv, ue;
  logic [TW-1:0] src [NI];
  logic [DW-1:0] trd [NT];
  always_comb begin
    for (int i = 0; i < NI; i++) begin
      dec[i] = '0;
      for (int t = NT - 1; t >= 0; t--)
        if ((i_addr[i*AW +: AW] & T_MASK[t*AW +: AW]) == T_BASE[t*AW +: AW]) begin
          dec[i] = '0;
          dec[i][t] = 1'b1;
        end
    end
  end
  always_comb begin
    treq = '0;
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < NI; i++) treq[t][i] = i_req[i] & dec[i][t];
  end
  for (genvar i = 0; i < NI; i++) begin : g_i
    assign mapped[i] = |dec[i];
  end
  assign unm = i_req & ~mapped;
  for (genvar t = 0; t < NT; t++) begin : g_t
    assign t_req[t] = |treq[t];
    assign trd[t] = t_rdata[t*DW +: DW];
    ccx_rr_arbiter #(.N(NI)) u_arb (
      .g_clk     (g_clk),
      .g_reset   (g_reset),
      .req       (treq[t]),
      .hold      (t_req[t] & ~t_gnt[t]),
      .accept    (t_req[t] & t_gnt[t]),
      .gnt_onehot(oh[t])
    );
  end
  always_comb begin
    t_rtype = '0;
    t_addr = '0;
    t_wen = '0;
    t_strb = '0;
    t_wdata = '0;
    i_gnt = unm;
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < NI; i++)
        if (oh[t][i]) begin
          t_rtype[t] = i_rtype[i];
          t_addr[t*AW +: AW] = i_addr[i*AW +: AW];
          t_wen[t] = i_wen[i];
          t_strb[t*SW +: SW] = i_strb[i*SW +: SW];
          t_wdata[t*DW +: DW] = i_wdata[i*DW +: DW];
          if (t_gnt[t]) i_gnt[i] = 1'b1;
        end
  end
  always_comb begin
    i_rdata = '0;
    i_err = '0;
    for (int i = 0; i < NI; i++) begin
      i_rdata[i*DW +: DW] = rv[i] ? trd[src[i]] : '0;
      i_err[i] = ue[i] | (rv[i] & t_err[src[i]]);
    end
  end
  always_ff @(posedge g_clk)
    if (g_reset) begin
      rv <= '0;
      ue <= '0;
    end else begin
      ue <= unm;
      rv <= '0;
      for (int i = 0; i < NI; i++)
        for (int t = 0; t < NT; t++)
          if (oh[t][i] & t_gnt[t]) begin
            rv[i] <= 1'b1;
            src[i] <= TW'(t);
          end
    end
endmodule

// File: tb/tb_ccx_ic_router.sv
// tb_ccx_ic_router: directed checks of decode, arbitration, lock, unmapped and reset
module tb_ccx_ic_router;
  localparam logic [4*39-1:0] TB_BASE = {39'h20_0000_0000, 39'h00_1000_0000, 39'h00_8000_0000, 39'h00_0000_0000};
  localparam logic [4*39-1:0] TB_MASK = {39'h7F_0000_0000, 39'h7F_F000_0000, 39'h7F_8000_0000, 39'h7F_F000_0000};
  localparam logic [38:0] RAM0 = 39'h00_8000_0000;
  localparam logic [38:0] RAM1 = 39'h00_8000_0008;
  logic g_clk, g_reset;
  logic [1:0] i_req, i_rtype, i_wen, i_gnt, i_err;
  logic [77:0] i_addr;
  logic [15:0] i_strb;
  logic [127:0] i_wdata, i_rdata;
  logic [3:0] t_req, t_rtype, t_wen, t_gnt, t_err;
  logic [155:0] t_addr;
  logic [31:0] t_strb;
  logic [255:0] t_wdata, t_rdata;
  int n_cmp = 0, n_bad = 0;
  ccx_ic_router #(.NI(2), .NT(4), .AW(39), .DW(64), .T_BASE(TB_BASE), .T_MASK(TB_MASK)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .i_req(i_req), .i_rtype(i_rtype), .i_addr(i_addr), .i_wen(i_wen), .i_strb(i_strb), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_err(i_err), .i_rdata(i_rdata),
    .t_req(t_req), .t_rtype(t_rtype), .t_addr(t_addr), .t_wen(t_wen), .t_strb(t_strb), .t_wdata(t_wdata),
    .t_gnt(t_gnt), .t_err(t_err), .t_rdata(t_rdata)
  );
  always #5 g_clk = ~g_clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask
  task automatic drv(input int i, input logic r, input logic [38:0] a, input logic w,
                     input logic [7:0] s, input logic [63:0] d);
    i_req[i] = r;
    i_rtype[i] = w;
    i_addr[i*39 +: 39] = a;
    i_wen[i] = w;
    i_strb[i*8 +: 8] = s;
    i_wdata[i*64 +: 64] = d;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    g_clk = 0;
    g_reset = 1;
    i_req = 0; i_rtype = 0; i_addr = 0; i_wen = 0; i_strb = 0; i_wdata = 0;
    t_gnt = 0; t_err = 0; t_rdata = 0;
    repeat (2) @(posedge g_clk);
    #1 g_reset = 0;
    #1;
    chk("rst_gnt", i_gnt, 0);
    chk("rst_err", i_err, 0);
    chk("rst_rdata", i_rdata, 0);
    chk("rst_treq", t_req, 0);
    chk("rst_taddr", t_addr, 0);
    t_gnt = 4'hF;
    for (int k = 0; k < 4; k++) begin
      drv(0, 1, RAM0, 0, 0, 64'h10);
      drv(1, 1, RAM1, 0, 0, 64'h11);
      t_rdata[127:64] = 64'hA000 + 64'(k);
      #1;
      chk("cont_gnt", i_gnt, (k % 2) ? 2'b10 : 2'b01);
      chk("cont_addr", t_addr[77:39], (k % 2) ? RAM1 : RAM0);
      if (k > 0) begin
        chk("cont_rsp", (k % 2) ? i_rdata[63:0] : i_rdata[127:64], 64'hA000 + 64'(k));
        chk("cont_idle", (k % 2) ? i_rdata[127:64] : i_rdata[63:0], 0);
      end
      tick();
    end
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    t_rdata[127:64] = 64'hA004;
    #1;
    chk("cont_last", i_rdata[127:64], 64'hA004);
    chk("cont_none", i_gnt, 0);
    tick();
    t_gnt = 0;
    drv(1, 1, RAM1, 0, 0, 0);
    #1;
    chk("stall_sel", t_addr[77:39], RAM1);
    chk("stall_gnt", i_gnt, 0);
    tick();
    for (int s = 0; s < 2; s++) begin
      drv(0, 1, RAM0, 0, 0, 0);
      #1;
      chk("stall_lock", t_addr[77:39], RAM1);
      chk("stall_gnt", i_gnt, 0);
      tick();
    end
    t_gnt = 4'hF;
    #1;
    chk("stall_acc", i_gnt, 2'b10);
    tick();
    t_rdata[127:64] = 64'hB001;
    #1;
    chk("stall_next", i_gnt, 2'b01);
    chk("stall_next_addr", t_addr[77:39], RAM0);
    chk("stall_rsp1", i_rdata[127:64], 64'hB001);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    t_rdata[127:64] = 64'hB002;
    #1;
    chk("stall_rsp0", i_rdata[63:0], 64'hB002);
    tick();
    drv(0, 1, 39'h7F_0000_0000, 0, 0, 0);
    t_rdata = {4{64'hFFFF_0000_FFFF_0000}};
    #1;
    chk("unm_gnt", i_gnt, 2'b01);
    chk("unm_treq", t_req, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("unm_err", i_err, 2'b01);
    chk("unm_rdata", i_rdata[63:0], 0);
    tick();
    chk("unm_clr", i_err, 0);
    drv(0, 1, 39'h00_1000_0040, 0, 0, 0);
    drv(1, 1, 39'h20_0000_0000, 0, 0, 0);
    t_rdata = 0;
    #1;
    chk("dec_treq", t_req, 4'b1100);
    chk("dec_gnt", i_gnt, 2'b11);
    tick();
    drv(0, 1, 39'h100, 0, 0, 0);
    drv(1, 1, 39'h00_8000_0010, 1, 8'hFF, 64'h1122334455667788);
    #1;
    chk("par_gnt", i_gnt, 2'b11);
    chk("par_treq", t_req, 4'b0011);
    chk("par_wen", t_wen, 4'b0010);
    chk("par_rtype", t_rtype, 4'b0010);
    chk("par_strb", t_strb, 32'h0000_FF00);
    chk("par_wdata", t_wdata[127:64], 64'h1122334455667788);
    chk("par_addr0", t_addr[38:0], 39'h100);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    t_rdata[63:0] = 64'hDEAD;
    t_rdata[127:64] = 64'hBEEF;
    t_err = 4'b0010;
    #1;
    chk("par_rd0", i_rdata[63:0], 64'hDEAD);
    chk("par_rd1", i_rdata[127:64], 64'hBEEF);
    chk("par_err", i_err, 2'b10);
    tick();
    t_err = 0;
    drv(0, 1, RAM0, 0, 0, 0);
    #1;
    chk("mr_gnt", i_gnt, 2'b01);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    t_rdata[127:64] = 64'hC0DE;
    t_err = 4'b0010;
    #1;
    chk("mr_rsp", i_rdata[63:0], 64'hC0DE);
    g_reset = 1;
    tick();
    chk("mr_rdata", i_rdata, 0);
    chk("mr_err", i_err, 0);
    g_reset = 0;
    tick();
    chk("mr_post_rdata", i_rdata, 0);
    chk("mr_post_err", i_err, 0);
    drv(0, 1, RAM0, 0, 0, 0);
    drv(1, 1, RAM1, 0, 0, 0);
    #1;
    chk("mr_ptr", i_gnt, 2'b01);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
